// File: rtl/spi_mem_pkg.sv
// Shared state encoding, output bundle and state-class helpers for the SPI memory slave sequencer.
package spi_mem_pkg;

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        ADDR_SHIFT   = 4'd1,
        GOT_ADDR     = 4'd2,
        READ_WAIT    = 4'd3,
        READ_LOAD    = 4'd4,
        READ_SHIFT   = 4'd5,
        WRITE_SHIFT  = 4'd6,
        WRITE_COMMIT = 4'd7,
        BURST_INC    = 4'd8,
        DONE         = 4'd9
    } state_t;

    localparam logic RW_READ = 1'b1;

    typedef struct packed {
        logic addr_we;
        logic sr_we;
        logic dm_we;
        logic addr_inc;
        logic miso_en;
        logic busy;
    } seq_out_t;

    function automatic logic is_shift_state(input state_t s);
        return (s == ADDR_SHIFT) || (s == READ_SHIFT) || (s == WRITE_SHIFT);
    endfunction

    // An SCLK edge in any of these states means the master is out of step with us.
    function automatic logic is_err_state(input state_t s);
        return (s == GOT_ADDR) || (s == READ_WAIT) || (s == READ_LOAD) ||
               (s == WRITE_COMMIT) || (s == BURST_INC) || (s == DONE);
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// SCLK edge counter: synchronous clear, increment on pulse, saturates at BITS.
// tc flags the last bit of a byte so the pulse that lands on it ends the byte.
module spi_bit_counter #(
    parameter int BITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int CW = $clog2(BITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BITS);
    localparam logic [CW-1:0] CNT_TC  = CW'(BITS - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_TC);

endmodule

// File: rtl/spi_mem_sequencer.sv
// Control FSM for the SPI memory slave: address latch, memory write, shift-register
// load and MISO enable, with optional burst auto-increment and protocol-error flag.
//
// state        | meaning
// IDLE         | CS high, waiting for a transaction
// ADDR_SHIFT   | shifting in the address/RW byte
// GOT_ADDR     | latch address, sample RW bit
// READ_WAIT    | waiting MEM_RD_LAT cycles for memory read data
// READ_LOAD    | load read data into the shift register
// READ_SHIFT   | shifting read data out on MISO
// WRITE_SHIFT  | shifting in a write data byte
// WRITE_COMMIT | write the received byte to memory
// BURST_INC    | bump the address latch before the next burst byte
// DONE         | transfer complete, waiting for CS high
module spi_mem_sequencer
    import spi_mem_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int MEM_RD_LAT = 1,
    parameter int BURST_EN   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_cond,
    input  logic sclk_pos,
    input  logic rw_bit,
    output logic sr_we,
    output logic dm_we,
    output logic addr_we,
    output logic addr_inc,
    output logic miso_en,
    output logic busy,
    output logic proto_err
);

    localparam logic [1:0] LAT_LOAD = (MEM_RD_LAT > 0) ? 2'(MEM_RD_LAT - 1) : 2'd0;
    localparam state_t     RD_ENTRY = (MEM_RD_LAT == 0) ? READ_LOAD : READ_WAIT;
    localparam logic       BURST    = (BURST_EN != 0);

    state_t   state;
    state_t   state_next;
    seq_out_t out_next;
    seq_out_t out_q;
    logic     cnt_tc;
    logic     last_read;
    logic [1:0] lat_cnt;

    spi_bit_counter #(
        .BITS (BITS)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (!is_shift_state(state)),
        .inc   (sclk_pos && is_shift_state(state)),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (cs_cond) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:         state_next = ADDR_SHIFT;
                ADDR_SHIFT:   if (sclk_pos && cnt_tc) state_next = GOT_ADDR;
                GOT_ADDR:     state_next = (rw_bit == RW_READ) ? RD_ENTRY : WRITE_SHIFT;
                READ_WAIT:    if (lat_cnt == 2'd0) state_next = READ_LOAD;
                READ_LOAD:    state_next = READ_SHIFT;
                READ_SHIFT:   if (sclk_pos && cnt_tc) state_next = BURST ? BURST_INC : DONE;
                WRITE_SHIFT:  if (sclk_pos && cnt_tc) state_next = WRITE_COMMIT;
                WRITE_COMMIT: state_next = BURST ? BURST_INC : DONE;
                BURST_INC:    state_next = last_read ? RD_ENTRY : WRITE_SHIFT;
                DONE:         state_next = DONE;
                default:      state_next = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so each strobe is
    // high exactly while the FSM sits in the matching state.
    always_comb begin
        out_next = '0;
        case (state_next)
            GOT_ADDR:     out_next.addr_we  = 1'b1;
            READ_LOAD:    out_next.sr_we    = 1'b1;
            READ_SHIFT:   out_next.miso_en  = 1'b1;
            WRITE_COMMIT: out_next.dm_we    = 1'b1;
            BURST_INC:    out_next.addr_inc = 1'b1;
            default:      out_next = '0;
        endcase
        out_next.busy = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_next;
        end
    end

    // Direction is remembered so burst continuation does not re-sample rw_bit,
    // which by then holds shifted data.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_read <= 1'b0;
        end else if (state == GOT_ADDR) begin
            last_read <= (rw_bit == RW_READ);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt <= LAT_LOAD;
        end else if (state == READ_WAIT) begin
            lat_cnt <= lat_cnt - 1'b1;
        end else begin
            lat_cnt <= LAT_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else if (cs_cond) begin
            proto_err <= 1'b0;
        end else if (sclk_pos && is_err_state(state)) begin
            proto_err <= 1'b1;
        end
    end

    assign addr_we  = out_q.addr_we;
    assign sr_we    = out_q.sr_we;
    assign dm_we    = out_q.dm_we;
    assign addr_inc = out_q.addr_inc;
    assign miso_en  = out_q.miso_en;
    assign busy     = out_q.busy;

endmodule

// File: tb/tb_spi_mem_sequencer.sv
// Bench for spi_mem_sequencer: three configurations driven with randomized SPI
// transactions; expected strobes come from a cycle timeline built while driving.
module tb_spi_mem_sequencer;

    localparam int B_AW = 4;
    localparam int B_SR = 3;
    localparam int B_DM = 2;
    localparam int B_AI = 1;
    localparam int BIG  = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs = 1'b1;
    logic sclk = 1'b0;
    logic rw = 1'b0;
    logic bad = 1'b0;
    logic rw_hold = 1'b0;
    logic chk_en = 1'b0;
    int   sel = 0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   miso_lo = 1;
    int   miso_hi = 0;
    logic [4:0] exp_ev [int];
    logic m_busy;
    logic m_perr;

    logic [2:0] cs_v, sclk_v;
    logic [2:0] sr_we_v, dm_we_v, addr_we_v, addr_inc_v, miso_en_v, busy_v, perr_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign cs_v[g]   = (sel == g) ? cs : 1'b1;
        assign sclk_v[g] = (sel == g) ? sclk : 1'b0;
        spi_mem_sequencer #(
            .BITS       (8),
            .MEM_RD_LAT ((g == 0) ? 2 : (g == 1) ? 1 : 0),
            .BURST_EN   ((g == 0) ? 0 : 1)
        ) u_dut (
            .clk       (clk),
            .reset     (rst),
            .cs_cond   (cs_v[g]),
            .sclk_pos  (sclk_v[g]),
            .rw_bit    (rw),
            .sr_we     (sr_we_v[g]),
            .dm_we     (dm_we_v[g]),
            .addr_we   (addr_we_v[g]),
            .addr_inc  (addr_inc_v[g]),
            .miso_en   (miso_en_v[g]),
            .busy      (busy_v[g]),
            .proto_err (perr_v[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    // busy follows CS one cycle later; proto_err latches on deliberately misplaced edges.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_perr <= 1'b0;
        end else begin
            m_busy <= !cs;
            if (cs) m_perr <= 1'b0;
            else if (sclk && bad) m_perr <= 1'b1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d sel=%0d act=%0h exp=%0h", tag, cyc, sel, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [4:0] e;
        if (chk_en) begin
            e = exp_ev.exists(cyc) ? exp_ev[cyc] : 5'b0;
            e[0] = (cyc >= miso_lo) && (cyc <= miso_hi);
            check_val("strobes", 32'({addr_we_v[sel], sr_we_v[sel], dm_we_v[sel],
                                      addr_inc_v[sel], miso_en_v[sel]}), 32'(e));
            check_val("busy", 32'(busy_v[sel]), 32'(m_busy));
            check_val("proto_err", 32'(perr_v[sel]), 32'(m_perr));
            check_val("others_idle", 32'(busy_v & ~(3'b001 << sel)), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        sclk = 1'b0;
        bad  = 1'b0;
        if (!rw_hold) rw = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse(input logic is_bad);
        sclk = 1'b1;
        bad  = is_bad;
        step();
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic mark(input int c, input int b);
        logic [4:0] v;
        v = exp_ev.exists(c) ? exp_ev[c] : 5'b0;
        v[b] = 1'b1;
        exp_ev[c] = v;
    endtask

    // Nothing the FSM would have done after the current cycle happens any more.
    task automatic cancel_future();
        int keys[$];
        foreach (exp_ev[k]) if (k > cyc) keys.push_back(k);
        foreach (keys[i]) exp_ev.delete(keys[i]);
        if (miso_hi > cyc) miso_hi = cyc;
    endtask

    task automatic cs_high(input logic with_pulse);
        cs   = 1'b1;
        sclk = with_pulse;
        bad  = 1'b0;
        cancel_future();
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cs  = 1'b1;
        cancel_future();
        repeat (3) step();
        rst = 1'b0;
        step();
    endtask

    // ab_byte: -1 = address byte, 0.. = data byte, anything larger = no abort.
    // ab_bit: edges shifted before CS rises; 8 = CS rises together with the last edge.
    task automatic txn(input int s, input bit rd, input int nbytes, input int ab_byte,
                       input int ab_bit, input bit err, input int done_extra, input int rst_bit);
        int  lat;
        bit  burst;
        bit  stop;
        int  a, d, load_c, last_ev;
        sel   = s;
        lat   = (s == 0) ? 2 : (s == 1) ? 1 : 0;
        burst = (s != 0);
        stop  = 0;
        a = 0; d = 0; load_c = 0; last_ev = 0;
        miso_lo = 1; miso_hi = 0;
        cs = 1'b0;
        step();
        gap();
        for (int b = 0; b < 8; b++) begin
            if (ab_byte == -1 && ab_bit == b) begin cs_high(1'b0); stop = 1; break; end
            if (b == 7) begin
                rw = rd; rw_hold = 1'b1;
                a = cyc;
                mark(a + 1, B_AW);
                last_ev = a + 1;
                if (ab_byte == -1 && ab_bit == 8) begin cs_high(1'b1); stop = 1; break; end
            end
            pulse(1'b0);
            if (b < 7) gap();
        end
        rw_hold = 1'b0;
        if (!stop) begin
            step();
            if (rd) begin
                load_c = a + 2 + lat;
                mark(load_c, B_SR);
                last_ev = load_c;
                miso_lo = load_c + 1;
                miso_hi = BIG;
            end
        end
        for (int j = 0; j < nbytes && !stop; j++) begin
            if (rd) begin
                if (err && j == 0) begin wait_until(load_c); pulse(1'b1); end
                wait_until(load_c + 1);
            end else begin
                wait_until((j == 0) ? a + 2 : d + 3);
            end
            gap();
            for (int b = 0; b < 8; b++) begin
                if (ab_byte == j && ab_bit == b) begin cs_high(1'b0); stop = 1; break; end
                if (rst_bit >= 0 && j == 0 && b == rst_bit) begin do_reset(); stop = 1; break; end
                if (b == 7) begin
                    d = cyc;
                    if (rd) begin
                        miso_hi = d;
                        if (burst) begin
                            mark(d + 1, B_AI);
                            load_c = d + 2 + lat;
                            mark(load_c, B_SR);
                            last_ev = load_c;
                        end
                    end else begin
                        mark(d + 1, B_DM);
                        last_ev = d + 1;
                        if (burst) begin mark(d + 2, B_AI); last_ev = d + 2; end
                    end
                    if (ab_byte == j && ab_bit == 8) begin cs_high(1'b1); stop = 1; break; end
                end
                pulse(1'b0);
                if (b < 7) gap();
            end
            if (!stop && rd && burst) begin miso_lo = load_c + 1; miso_hi = BIG; end
            if (!stop && !rd && err && j == 0) pulse(1'b1);
        end
        if (!stop) begin
            if (burst) begin
                wait_until(last_ev);
                cs_high(1'b0);
            end else begin
                wait_until(rd ? d + 1 : d + 2);
                for (int e = 0; e < done_extra; e++) begin gap(); pulse(1'b1); end
                gap();
                cs_high(1'b0);
            end
        end
        repeat (2) step();
    endtask

    initial begin
        int s, nb, abb, abt, de;
        bit rd, er;
        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) step();

        txn(0, 0, 1, 99, 0, 0, 0, -1);   // plain write
        txn(0, 1, 1, 99, 0, 0, 0, -1);   // plain read
        txn(0, 0, 1, 0, 4, 0, 0, -1);    // abort mid write byte
        txn(0, 0, 1, 0, 8, 0, 0, -1);    // abort together with last write edge
        txn(1, 0, 2, 99, 0, 0, 0, -1);   // burst write, two bytes
        txn(1, 1, 3, 99, 0, 0, 0, -1);   // burst read
        txn(2, 1, 2, 99, 0, 0, 0, -1);   // burst read, zero read latency
        txn(0, 1, 1, 99, 0, 1, 1, -1);   // edge in READ_LOAD and in DONE
        txn(0, 0, 1, 99, 0, 1, 0, -1);   // edge in WRITE_COMMIT
        txn(0, 1, 1, 99, 0, 0, 0, 3);    // reset during READ_SHIFT
        txn(0, 0, 1, 99, 0, 0, 0, -1);   // recovery after reset

        for (int t = 0; t < 80; t++) begin
            s   = $urandom_range(0, 2);
            rd  = 1'($urandom_range(0, 1));
            nb  = (s == 0) ? 1 : $urandom_range(1, 3);
            er  = ($urandom_range(0, 3) == 0);
            de  = (s == 0) ? $urandom_range(0, 2) : 0;
            if ($urandom_range(0, 9) < 3) begin
                abb = $urandom_range(0, nb) - 1;
                abt = $urandom_range(0, 8);
            end else begin
                abb = 99;
                abt = 0;
            end
            txn(s, rd, nb, abb, abt, er, de, -1);
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
